// File: rtl/alu_result_fifo_if.sv
// ALU result FIFO bus: upstream push side (valid/ready + result, flag, ALUop)
// and downstream pop side (valid/ready + head entry fields).
// The master modport is the environment; the slave modport is the FIFO.
interface alu_result_fifo_if #(
  parameter int WIDTH = 32
);
  // Upstream (arithmetic stage -> FIFO)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic [3:0]       ALUop;

  // Downstream (FIFO -> consumer)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_flag;
  logic [3:0]       out_op;

  modport master (
    output in_valid,
    output result,
    output flag,
    output ALUop,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_flag,
    input  out_op
  );

  modport slave (
    input  in_valid,
    input  result,
    input  flag,
    input  ALUop,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_flag,
    output out_op
  );
endinterface : alu_result_fifo_if

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO holding {result, flag, ALUop} from an ALU stage.
// DEPTH must be a power of two (2..16) so pointers wrap by natural overflow.
// Optional feature: define ALU_STICKY_FLAG_EN to build the sticky overflow
// flag register; without it flag_sticky is tied to 0 and flag_clr is ignored.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_result_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   flag_sticky,
  input  logic                   flag_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + 5;  // result + flag + 4-bit opcode tag

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Storage carries no reset: pointer reset alone discards its contents.
  logic [ENT_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode (registered state only, so no ready/valid pass-through)
  // ---------------------------------------------------------------------------
  logic not_full;
  logic not_empty;
  logic push;
  logic pop;

  assign not_full  = (count_q < DEPTH_C);
  assign not_empty = (count_q != '0);
  assign push      = bus.in_valid & not_full;
  assign pop       = bus.out_ready & not_empty;

  // ---------------------------------------------------------------------------
  // Next-state: pointers advance independently, count tracks the net change
  // ---------------------------------------------------------------------------
  // Compute pointer and occupancy updates for this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves occupancy unchanged. push is already
    // gated by not_full and pop by not_empty, so count stays in 0..DEPTH.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write / head read
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] head_entry;

  assign wr_entry = {bus.result, bus.flag, bus.ALUop};

  // Write the accepted entry at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Asynchronous head read gives fall-through: an entry pushed on an edge is
  // on out_* right after that edge. Outputs read zero while empty, which also
  // hides stale storage after reset.
  always_comb begin
    head_entry = '0;
    if (not_empty) begin
      head_entry = mem[rd_ptr_q];
    end
  end

  assign bus.in_ready   = not_full;
  assign bus.out_valid  = not_empty;
  assign bus.out_result = head_entry[ENT_W-1:5];
  assign bus.out_flag   = head_entry[4];
  assign bus.out_op     = head_entry[3:0];
  assign count          = count_q;

  // ---------------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------------
`ifdef ALU_STICKY_FLAG_EN
  logic sticky_q, sticky_d;

  // Set on any accepted push carrying flag=1; a coincident clear loses.
  always_comb begin
    sticky_d = sticky_q;
    if (push && bus.flag) begin
      sticky_d = 1'b1;
    end else if (flag_clr) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky flag register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign flag_sticky = sticky_q;
`else
  // Feature not built: the clear input is accepted but has no effect.
  logic flag_clr_unused;
  assign flag_clr_unused = flag_clr;
  assign flag_sticky     = 1'b0;
`endif

endmodule : alu_result_fifo

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed steps followed by a random phase, all
// checked every cycle against a queue-based model of the FIFO.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic       clk;
  logic       rst_n;
  logic       flag_clr;
  logic       flag_sticky;
  logic [2:0] count;

  alu_result_fifo_if #(.WIDTH(WIDTH)) bif ();

  alu_result_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .count      (count),
    .flag_sticky(flag_sticky),
    .flag_clr   (flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        f;
    logic [3:0]  op;
  } ent_t;

  ent_t model_q[$];
  bit   exp_sticky;
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's view of the FIFO.
  task automatic check_all(input string ctx);
    int   sz;
    ent_t h;
    sz = model_q.size();
    h  = '{32'h0, 1'b0, 4'h0};
    if (sz != 0) h = model_q[0];
    chk({ctx, ".count"},      64'(count),          64'(sz));
    chk({ctx, ".in_ready"},   64'(bif.in_ready),   64'(sz < DEPTH));
    chk({ctx, ".out_valid"},  64'(bif.out_valid),  64'(sz != 0));
    chk({ctx, ".out_result"}, 64'(bif.out_result), 64'(h.r));
    chk({ctx, ".out_flag"},   64'(bif.out_flag),   64'(h.f));
    chk({ctx, ".out_op"},     64'(bif.out_op),     64'(h.op));
    chk({ctx, ".sticky"},     64'(flag_sticky),    64'(exp_sticky));
  endtask

  task automatic drive(input bit v, input logic [31:0] r, input bit f,
                       input logic [3:0] op, input bit ordy, input bit clr);
    bif.in_valid  = v;
    bif.result    = r;
    bif.flag      = f;
    bif.ALUop     = op;
    bif.out_ready = ordy;
    flag_clr      = clr;
  endtask

  // Advance one clock edge, update the model from the inputs presented
  // before the edge, then check outputs 1 time unit after the edge.
  task automatic step(input string ctx);
    bit   acc;
    bit   pp;
    ent_t e;
    acc  = bif.in_valid && (model_q.size() < DEPTH);
    pp   = bif.out_ready && (model_q.size() != 0);
    e.r  = bif.result;
    e.f  = bif.flag;
    e.op = bif.ALUop;
`ifdef ALU_STICKY_FLAG_EN
    if (acc && e.f) exp_sticky = 1'b1;
    else if (flag_clr) exp_sticky = 1'b0;
`endif
    @(posedge clk);
    if (pp) void'(model_q.pop_front());
    if (acc) model_q.push_back(e);
    #1;
    check_all(ctx);
    $display("step %-10s count=%0d in_rdy=%0d out_v=%0d out=%h/%0d/%h sticky=%0d",
             ctx, count, bif.in_ready, bif.out_valid, bif.out_result,
             bif.out_flag, bif.out_op, flag_sticky);
  endtask

  initial begin
    logic [31:0] vals [4];
    n_cmp      = 0;
    n_err      = 0;
    exp_sticky = 1'b0;
    vals[0] = 32'h16; vals[1] = 32'h24; vals[2] = 32'h18; vals[3] = 32'hFFFF_FFFE;

    // Reset state
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 4'h0, 0, 0);
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;

    // Single push, visible the next cycle
    drive(1, 32'h16, 0, 4'h2, 0, 0);
    step("push1");
    drive(0, 32'h0, 0, 4'h0, 1, 0);
    step("pop1");

    // Fill to DEPTH with out_ready=0, then an ignored 5th push (flag=1 must
    // not touch the sticky flag), then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, vals[i], 0, 4'(i + 3), 0, 0);
      step("fill");
    end
    drive(1, 32'hDEAD_BEEF, 1, 4'hF, 0, 0);
    step("full_push");
    drive(1, 32'hDEAD_BEEF, 1, 4'hF, 0, 0);
    step("full_hold");
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 0, 4'h0, 1, 0);
      step("drain");
    end

    // Hold count=2 with simultaneous push/pop across pointer wrap
    drive(1, 32'h100, 0, 4'h1, 0, 0);
    step("pre_a");
    drive(1, 32'h101, 0, 4'h2, 0, 0);
    step("pre_b");
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom, 1'($urandom_range(0, 1) & 0), 4'($urandom_range(0, 15)), 1, 0);
      step("pushpop");
    end

    // Sticky flag: set, set-wins-over-clear, clear alone
    drive(1, 32'hFFFF_FFFE, 1, 4'h3, 0, 0);
    step("stk_set");
    drive(1, 32'h55, 1, 4'h4, 0, 1);
    step("stk_race");
    drive(0, 32'h0, 0, 4'h0, 0, 1);
    step("stk_clr");
    drive(0, 32'h0, 0, 4'h0, 0, 0);
    step("stk_idle");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 9) == 0));
      step("random");
    end

    // Async reset between edges with count=3
    drive(0, 32'h0, 0, 4'h0, 0, 0);
    rst_n = 1'b0;
    model_q.delete();
    exp_sticky = 1'b0;
    #1;
    check_all("rst_clean");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(i), 1, 4'(i), 0, 0);
      step("pre_rst");
    end
    drive(0, 32'h0, 0, 4'h0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_q.delete();
    exp_sticky = 1'b0;
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
    drive(1, 32'hA5A5_0001, 0, 4'h9, 0, 0);
    step("post_rst");
    drive(0, 32'h0, 0, 4'h0, 1, 0);
    step("post_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_result_fifo

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16 SHALL be supported.
REQ-002 Parameter WIDTH, default 32, result data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream arithmetic-stage result present.
REQ-006 in_ready  output  1  FIFO can accept an entry this cycle.
REQ-007 result  input  WIDTH  arithmetic-stage result.
REQ-008 flag  input  1  arithmetic-stage overflow/carry flag.
REQ-009 ALUop  input  4  opcode that produced the result, stored as tag.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_result  output  WIDTH  head entry result.
REQ-013 out_flag  output  1  head entry flag.
REQ-014 out_op  output  4  head entry opcode tag.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 flag_sticky  output  1  any pushed entry had flag=1 since last clear.
REQ-017 flag_clr  input  1  synchronous clear of flag_sticky.

Function
REQ-018 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; {result, flag, ALUop} written at write pointer.
REQ-019 Pop SHALL occur on a rising edge where out_valid=1 and out_ready=1; read pointer advances.
REQ-020 in_ready SHALL equal (count < DEPTH), derived from registered state only; no pass-through when full.
REQ-021 out_valid SHALL equal (count != 0); first-word fall-through: pushed entry visible on out_* in the cycle after its push edge (latency 1).
REQ-022 out_result, out_flag, out_op SHALL be 0 whenever out_valid=0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order (strict FIFO).
REQ-025 Push with in_ready=0 SHALL be ignored; no state change, no sticky update.
REQ-026 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-028 rst_n=0 SHALL immediately clear pointers, count, flag_sticky; out_valid=0, in_ready=1, out_* = 0.
REQ-029 Storage array SHALL NOT require reset; contents are discarded by pointer reset.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; first push after release lands at head.

Configuration
REQ-031 Macro ALU_STICKY_FLAG_EN defined: flag_sticky SHALL set on any accepted push with flag=1, clear on flag_clr=1; set wins when push-with-flag and flag_clr coincide.
REQ-032 Macro ALU_STICKY_FLAG_EN undefined: flag_sticky SHALL be constant 0, flag_clr ignored, no sticky register synthesised.

Verification
REQ-033 Reset, then push result=0x16 flag=0 ALUop=0x2 -> next cycle out_valid=1, out_result=0x16, out_op=0x2, count=1.
REQ-034 Push 4 entries (0x16, 0x24, 0x18, 0xFFFFFFFE) with out_ready=0 -> count=4, in_ready=0; 5th push ignored; drain yields same 4 values in order, then out_valid=0, out_* = 0.
REQ-035 Hold count=2, assert in_valid and out_ready together for 6 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-036 With ALU_STICKY_FLAG_EN: push result=0xFFFFFFFE flag=1 -> flag_sticky=1 next cycle; flag_clr=1 same cycle as another flag=1 push -> flag_sticky stays 1; flag_clr alone -> 0. Without macro -> flag_sticky always 0.
REQ-037 With count=3, drop rst_n between clock edges -> count=0, out_valid=0, in_ready=1 immediately, before next edge.
